// File: rtl/dma_dev_bridge.sv
// dma_dev_bridge: device-side front end that feeds/drains the DMA controller through a small buffer.
// Define DMA_BRIDGE_TIMEOUT_EN to enable the XFER stall watchdog (status 10).
module dma_dev_bridge #(
    parameter int ADD_LEN = 16,
    parameter int DATA_LEN = 16,
    parameter int BUF_AW = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [ADD_LEN:0]    cmd_addr,
    input  logic [ADD_LEN-1:0]  cmd_len,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [DATA_LEN-1:0] src_data,
    output logic                snk_valid,
    input  logic                snk_ready,
    output logic [DATA_LEN-1:0] snk_data,
    output logic                rqst,
    output logic [ADD_LEN-1:0]  num_words,
    output logic [ADD_LEN:0]    start_addr,
    output logic                rd_wr,
    output logic                dev_ack,
    output logic [DATA_LEN-1:0] dev_in,
    input  logic [DATA_LEN-1:0] dev_out,
    input  logic                dma_ack,
    input  logic                end_flag,
    output logic                done,
    output logic [1:0]          status,
    output logic [ADD_LEN-1:0]  words_done
);
    localparam int DEPTH = 1 << BUF_AW;
    typedef enum logic [2:0] {SETTLE, IDLE, CHECK, ISSUE, XFER, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic settle_cnt;
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [BUF_AW-1:0] wr_ptr, rd_ptr;
    logic [BUF_AW:0] count;
    logic [ADD_LEN-1:0] fetched, words_next;
    logic [1:0] status_n;
    logic xfer, empty, full, accept, push, pop, timeout;

    assign xfer = state == XFER;
    assign empty = count == '0;
    assign full = count == (BUF_AW+1)'(DEPTH);
    assign cmd_ready = state == IDLE;
    assign accept = cmd_valid && cmd_ready;
    assign rqst = state == ISSUE;
    assign done = state == DONE;
    assign src_ready = xfer && !rd_wr && !full && fetched < num_words;
    assign snk_valid = (xfer || state == DRAIN) && rd_wr && !empty;
    assign dev_in = rd_wr ? '0 : mem[rd_ptr];
    assign snk_data = rd_wr ? mem[rd_ptr] : '0;
    // The controller moves a word the cycle after it samples dev_ack, so keep one word of slack.
    assign dev_ack = xfer && (rd_wr ? int'(count) <= DEPTH - 2
                                    : int'(count) >= 2 || (!empty && fetched == num_words));
    assign push = rd_wr ? xfer && dma_ack : src_valid && src_ready;
    assign pop = rd_wr ? snk_valid && snk_ready : xfer && dma_ack;
    assign words_next = words_done + ADD_LEN'(xfer && dma_ack);

`ifdef DMA_BRIDGE_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;
    logic stall;
    assign stall = xfer && !dma_ack && !end_flag;
    assign timeout = stall && int'(wd_cnt) == TIMEOUT_CYCLES - 1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wd_cnt <= '0;
        else wd_cnt <= stall ? wd_cnt + WDW'(1) : '0;
    end
`else
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        state_n = state;
        status_n = status;
        case (state)
            SETTLE: state_n = settle_cnt ? IDLE : SETTLE;
            IDLE: begin
                state_n = accept ? CHECK : IDLE;
                status_n = accept ? 2'b00 : status;
            end
            CHECK: begin
                state_n = start_addr[0] ? DONE : ISSUE;
                status_n = start_addr[0] ? 2'b11 : 2'b00;
            end
            ISSUE: state_n = XFER;
            XFER: begin
                if (timeout) begin
                    state_n = DONE;
                    status_n = 2'b10;
                end else if (end_flag) begin
                    state_n = rd_wr ? DRAIN : DONE;
                    status_n = {1'b0, words_next != num_words};
                end
            end
            DRAIN: state_n = empty ? DONE : DRAIN;
            DONE: state_n = IDLE;
            default: state_n = SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SETTLE;
            settle_cnt <= 1'b0;
            status <= '0;
            num_words <= '0;
            start_addr <= '0;
            rd_wr <= 1'b0;
            words_done <= '0;
            fetched <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_n;
            status <= status_n;
            settle_cnt <= state == SETTLE;
            if (accept) begin
                num_words <= cmd_len;
                start_addr <= cmd_addr;
                rd_wr <= cmd_dir;
                words_done <= '0;
                fetched <= '0;
            end else begin
                words_done <= words_next;
                if (!rd_wr && push) fetched <= fetched + ADD_LEN'(1);
            end
            if (accept || timeout) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                if (push) mem[wr_ptr] <= rd_wr ? dev_out : src_data;
                if (push) wr_ptr <= wr_ptr + BUF_AW'(1);
                if (pop) rd_ptr <= rd_ptr + BUF_AW'(1);
                count <= count + (BUF_AW+1)'(push) - (BUF_AW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_dma_dev_bridge.sv
// tb_dma_dev_bridge: directed bench for dma_dev_bridge with a small DMA controller model.
module tb_dma_dev_bridge;
    logic clk = 0;
    logic reset;
    logic cmd_valid, cmd_ready, cmd_dir;
    logic [16:0] cmd_addr, start_addr;
    logic [15:0] cmd_len, num_words, words_done;
    logic src_valid, src_ready, snk_valid, snk_ready;
    logic [15:0] src_data, snk_data, dev_in, dev_out;
    logic rqst, rd_wr, dev_ack, dma_ack, end_flag, done;
    logic [1:0] status;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dma_dev_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
        .rqst(rqst), .num_words(num_words), .start_addr(start_addr), .rd_wr(rd_wr),
        .dev_ack(dev_ack), .dev_in(dev_in), .dev_out(dev_out),
        .dma_ack(dma_ack), .end_flag(end_flag),
        .done(done), .status(status), .words_done(words_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input string tag);
        reset = 1;
        check({tag, "_settle0"}, 32'(cmd_ready), 0);
        step();
        check({tag, "_settle1"}, 32'(cmd_ready), 0);
        step();
        check({tag, "_ready"}, 32'(cmd_ready), 1);
    endtask

    // Issues one command and plays the controller: a word moves the cycle after dev_ack was seen.
    task automatic run_cmd(input logic dir, input logic [16:0] addr, input logic [15:0] len,
                           input int limit, input int end_delay, input bit hold_sink, input bit abort,
                           output int cyc_done, output int acc_cyc, output int rq_cyc,
                           output int n_rqst, output int viol, output int n_snk, output int last_pop,
                           output logic [1:0] st, output logic [15:0] wd);
        int cyc = 0, acked = 0, src_i = 0, occ = 0, last_ev = 0;
        bit pend = 0, started = 0, ended = 0, stop = 0, drop = 0, push, pop, ack_now;
        cyc_done = -1; acc_cyc = -1; rq_cyc = -1; n_rqst = 0; viol = 0; n_snk = 0; last_pop = -1;
        st = '0; wd = '0;
        cmd_valid = 1; cmd_dir = dir; cmd_addr = addr; cmd_len = len;
        while (cyc < 300 && cyc_done < 0 && !stop) begin
            ack_now = pend && !ended && acked < limit;
            dma_ack = ack_now;
            dev_out = ack_now ? 16'(32'hB1 + acked) : '0;
            if (ack_now && !dir) check("dev_in", 32'(dev_in), 32'hA1 + acked);
            if (rqst) begin
                n_rqst++;
                started = 1;
                rq_cyc = cyc;
                last_ev = cyc;
                check("start_addr", 32'(start_addr), 32'(addr));
                check("num_words", 32'(num_words), 32'(len));
                check("rd_wr", 32'(rd_wr), 32'(dir));
            end
            if (ack_now) begin
                acked++;
                last_ev = cyc;
            end
            end_flag = started && !ended && acked == limit && cyc == last_ev + end_delay;
            if (end_flag) ended = 1;
            src_valid = !dir && src_i < int'(len);
            src_data = src_valid ? 16'(32'hA1 + src_i) : '0;
            snk_ready = !hold_sink && cyc % 2 == 1;
            push = dir ? ack_now : src_valid && src_ready;
            pop = dir ? snk_valid && snk_ready : ack_now;
            if (dir && snk_valid && snk_ready) begin
                check("snk_data", 32'(snk_data), 32'hB1 + n_snk);
                n_snk++;
                last_pop = cyc;
            end
            if ((pop && occ == 0) || occ + int'(push) - int'(pop) > 4 || (dir && dev_ack && occ > 2))
                viol++;
            occ = occ + int'(push) - int'(pop);
            pend = dev_ack;
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                drop = 1;
            end
            if (done) begin
                cyc_done = cyc;
                st = status;
                wd = words_done;
            end
            if (abort && acked == limit && cyc == last_ev + 1) stop = 1;
            step();
            cyc++;
            if (push && !dir) src_i++;
            if (drop) begin
                cmd_valid = 0;
                drop = 0;
            end
        end
        dma_ack = 0; end_flag = 0; src_valid = 0; snk_ready = 0; dev_out = '0; src_data = '0;
        cmd_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int cd, ac, rc, nr, vi, ns, lp, seen;
        logic [1:0] st;
        logic [15:0] wd;
        reset = 1; cmd_valid = 0; cmd_dir = 0; cmd_addr = '0; cmd_len = '0;
        src_valid = 0; src_data = '0; snk_ready = 0; dev_out = '0; dma_ack = 0; end_flag = 0;
        #2 reset = 0;
        repeat (2) step();
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_outs", 32'({rqst, done, dev_ack, snk_valid, src_ready, rd_wr, status}), 0);
        check("rst_words", 32'({num_words, words_done}), 0);
        check("rst_data", 32'({dev_in, snk_data}), 0);
        check("rst_addr", 32'(start_addr), 0);
        settle("init");

        run_cmd(0, 17'h0200, 16'd3, 3, 1, 0, 0, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("wr_rqst", nr, 1);
        check("wr_done_seen", 32'(cd >= 0), 1);
        check("wr_status", 32'(st), 0);
        check("wr_words", 32'(wd), 3);
        check("wr_viol", vi, 0);
        check("wr_done_pulse", 32'(done), 0);
        check("wr_idle", 32'(cmd_ready), 1);

        run_cmd(1, 17'h0400, 16'd4, 4, 1, 0, 0, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("rd_done_seen", 32'(cd >= 0), 1);
        check("rd_status", 32'(st), 0);
        check("rd_words", 32'(wd), 4);
        check("rd_sink_cnt", ns, 4);
        check("rd_viol", vi, 0);
        check("rd_done_after_pop", 32'(cd > lp), 1);

        run_cmd(0, 17'h0300, 16'd0, 0, 2, 0, 0, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("zl_rqst", nr, 1);
        check("zl_latency", cd - rc, 3);
        check("zl_status", 32'(st), 0);
        check("zl_words", 32'(wd), 0);

        run_cmd(0, 17'h0201, 16'd2, 2, 1, 0, 0, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("mis_rqst", nr, 0);
        check("mis_latency", cd - ac, 2);
        check("mis_status", 32'(st), 3);

        run_cmd(0, 17'h0100, 16'd8, 5, 0, 0, 0, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("early_status", 32'(st), 1);
        check("early_words", 32'(wd), 5);
        check("early_viol", vi, 0);

        run_cmd(1, 17'h0600, 16'd4, 2, 1000, 1, 1, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("abort_no_done_xfer", cd, -1);
        check("abort_buffered", 32'(snk_valid), 1);
        reset = 0;
        #1;
        check("abort_outs", 32'({rqst, done, dev_ack, snk_valid, src_ready, rd_wr, cmd_ready}), 0);
        check("abort_words", 32'({num_words, words_done}), 0);
        check("abort_addr", 32'(start_addr), 0);
        seen = 0;
        repeat (3) begin
            step();
            seen += int'(done);
        end
        check("abort_no_done", seen, 0);
        settle("abort");

        run_cmd(0, 17'h0800, 16'd1, 1, 1, 0, 0, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("rec_status", 32'(st), 0);
        check("rec_words", 32'(wd), 1);

`ifdef DMA_BRIDGE_TIMEOUT_EN
        run_cmd(0, 17'h0200, 16'd2, 0, 100000, 0, 0, cd, ac, rc, nr, vi, ns, lp, st, wd);
        check("to_status", 32'(st), 2);
        check("to_words", 32'(wd), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
